// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_arb_pkg;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_XLEN     = 32;
  localparam int RF_LAST_REG = 31;

  typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_LONG, GNT_DBG} gnt_t;
  typedef enum logic {ST_INIT, ST_RUN} rf_arb_state_t;
endpackage

// File: rtl/rf_arb_starve_ctr.sv
// Saturating wait counter for one secondary requester; flags when it reaches LIMIT.
module rf_arb_starve_ctr #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic ready,
  output logic starved
);
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (!valid || ready)   cnt <= '0;
    else if (cnt != 8'(LIMIT))  cnt <= cnt + 8'd1;
  end

  assign starved = (cnt == 8'(LIMIT));
endmodule

// File: rtl/rf_write_arbiter.sv
// Single write port of the 32x32 register file: zero-sweep after reset, then
// WB-first arbitration with round-robin between the long unit and debug port.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 WB_WE,
  input  logic [RF_ADDR_W-1:0] WB_ADDR,
  input  logic [RF_XLEN-1:0]   WB_DATA,
  input  logic                 LONG_VALID,
  input  logic [RF_ADDR_W-1:0] LONG_ADDR,
  input  logic [RF_XLEN-1:0]   LONG_DATA,
  output logic                 LONG_READY,
  input  logic                 DBG_VALID,
  input  logic [RF_ADDR_W-1:0] DBG_ADDR,
  input  logic [RF_XLEN-1:0]   DBG_DATA,
  output logic                 DBG_READY,
  output logic                 WE3,
  output logic [RF_ADDR_W-1:0] A3,
  output logic [RF_XLEN-1:0]   WD3,
  output logic                 INIT_BUSY,
  output logic                 WB_HOLD,
  output logic                 WB_DROP_ERR
);
  rf_arb_state_t        state, state_nxt;
  logic [RF_ADDR_W-1:0] cnt;
  logic                 rr;
  logic                 drop_err;
  gnt_t                 gnt;
  logic                 long_starved, dbg_starved;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
    else        state <= state_nxt;
  end

  // Write-port outputs are gated by RST_N so the port is quiet while reset is held.
  always_comb begin
    state_nxt  = state;
    gnt        = GNT_NONE;
    WE3        = 1'b0;
    A3         = '0;
    WD3        = '0;
    LONG_READY = 1'b0;
    DBG_READY  = 1'b0;
    if (RST_N) begin
      if (state == ST_INIT) begin
        WE3 = 1'b1;
        A3  = cnt;
        if (cnt == RF_ADDR_W'(RF_LAST_REG)) state_nxt = ST_RUN;
      end else begin
        if (WB_WE)                          gnt = GNT_WB;
        else if (LONG_VALID && DBG_VALID)   gnt = rr ? GNT_DBG : GNT_LONG;
        else if (LONG_VALID)                gnt = GNT_LONG;
        else if (DBG_VALID)                 gnt = GNT_DBG;
        case (gnt)
          GNT_WB: begin
            WE3 = (WB_ADDR != '0);
            A3  = WB_ADDR;
            WD3 = WB_DATA;
          end
          GNT_LONG: begin
            LONG_READY = 1'b1;
            WE3 = (LONG_ADDR != '0);
            A3  = LONG_ADDR;
            WD3 = LONG_DATA;
          end
          GNT_DBG: begin
            DBG_READY = 1'b1;
            WE3 = (DBG_ADDR != '0);
            A3  = DBG_ADDR;
            WD3 = DBG_DATA;
          end
          default: ;
        endcase
      end
    end
  end

  // rr points at the secondary that did not win the last handshake.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt      <= RF_ADDR_W'(1);
      rr       <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      if (state == ST_INIT) begin
        cnt <= cnt + RF_ADDR_W'(1);
        if (WB_WE) drop_err <= 1'b1;
      end
      if (gnt == GNT_LONG)     rr <= 1'b1;
      else if (gnt == GNT_DBG) rr <= 1'b0;
    end
  end

  rf_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_long_starve (
    .clk(CLK), .rst_n(RST_N), .valid(LONG_VALID), .ready(LONG_READY), .starved(long_starved)
  );

  rf_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_dbg_starve (
    .clk(CLK), .rst_n(RST_N), .valid(DBG_VALID), .ready(DBG_READY), .starved(dbg_starved)
  );

  assign INIT_BUSY   = (state == ST_INIT);
  assign WB_HOLD     = long_starved | dbg_starved;
  assign WB_DROP_ERR = drop_err;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: vector table, corner sequences, random vs model.
module tb_rf_write_arbiter;
  localparam int LIM = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we, lv, dv;
  logic [4:0]  wb_a, la, da;
  logic [31:0] wb_d, ld, dd;
  logic        lr, dr, we3, busy, hold, err;
  logic [4:0]  a3;
  logic [31:0] wd3;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  a;
    logic [31:0] wd;
    logic        lr, dr, busy, hold, err;
  } obs_t;

  typedef struct {
    logic        wb_we; logic [4:0] wb_a; logic [31:0] wb_d;
    logic        lv;    logic [4:0] la;   logic [31:0] ld;
    logic        dv;    logic [4:0] da;   logic [31:0] dd;
    obs_t        exp;
  } vec_t;

  rf_write_arbiter #(.CLEAR_ON_RESET(1'b1), .STARVE_LIMIT(LIM)) dut (
    .CLK(clk), .RST_N(rst_n),
    .WB_WE(wb_we), .WB_ADDR(wb_a), .WB_DATA(wb_d),
    .LONG_VALID(lv), .LONG_ADDR(la), .LONG_DATA(ld), .LONG_READY(lr),
    .DBG_VALID(dv), .DBG_ADDR(da), .DBG_DATA(dd), .DBG_READY(dr),
    .WE3(we3), .A3(a3), .WD3(wd3),
    .INIT_BUSY(busy), .WB_HOLD(hold), .WB_DROP_ERR(err)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(logic we, logic [4:0] a, logic [31:0] wd,
                              logic r_l, logic r_d, logic b, logic h, logic e);
    obs_t o;
    o.we = we; o.a = a; o.wd = wd; o.lr = r_l; o.dr = r_d; o.busy = b; o.hold = h; o.err = e;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    return mk(we3, a3, wd3, lr, dr, busy, hold, err);
  endfunction

  function automatic vec_t v(logic w, logic [4:0] wa, logic [31:0] wdd,
                             logic l, logic [4:0] laa, logic [31:0] ldd,
                             logic d, logic [4:0] daa, logic [31:0] ddd, obs_t e);
    vec_t r;
    r.wb_we = w; r.wb_a = wa; r.wb_d = wdd;
    r.lv = l; r.la = laa; r.ld = ldd;
    r.dv = d; r.da = daa; r.dd = ddd;
    r.exp = e;
    return r;
  endfunction

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got we=%b a=%0d wd=%h lr=%b dr=%b busy=%b hold=%b err=%b, want we=%b a=%0d wd=%h lr=%b dr=%b busy=%b hold=%b err=%b",
               name, act.we, act.a, act.wd, act.lr, act.dr, act.busy, act.hold, act.err,
               exp.we, exp.a, exp.wd, exp.lr, exp.dr, exp.busy, exp.hold, exp.err);
    end
  endtask

  task automatic idle();
    wb_we = 0; wb_a = 0; wb_d = 0;
    lv = 0; la = 0; ld = 0;
    dv = 0; da = 0; dd = 0;
  endtask

  // Holds reset for two edges, checks the reset outputs, releases just after an edge.
  task automatic do_reset();
    rst_n = 0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", dut_obs(), mk(0, 0, 0, 0, 0, 1, 0, 0));
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  // Expects x1..x31 zeroed on consecutive cycles; optionally pulses WB_WE on one sweep cycle.
  task automatic sweep(input int pulse_at);
    for (int i = 1; i <= 31; i++) begin
      wb_we = (i == pulse_at); wb_a = 5'd3; wb_d = 32'hFFFF_FFFF;
      @(negedge clk);
      chk($sformatf("sweep_x%0d", i), dut_obs(),
          mk(1, 5'(i), 0, 0, 0, 1, 0, (pulse_at > 0) && (i > pulse_at)));
      @(posedge clk);
      #1;
    end
    idle();
    @(negedge clk);
    chk("sweep_done", dut_obs(), mk(0, 0, 0, 0, 0, 0, 0, pulse_at > 0));
    @(posedge clk);
    #1;
  endtask

  // Reference model state: sweep progress, fairness owner, per-port wait counts, error flag.
  bit m_init;
  int m_idx, m_rr, m_wl, m_wd;
  bit m_err;

  function automatic obs_t model_eval();
    obs_t e;
    e = '0;
    e.busy = m_init;
    e.err  = m_err;
    e.hold = (m_wl == LIM) || (m_wd == LIM);
    if (m_init) begin
      e.we = 1; e.a = 5'(m_idx);
    end else if (wb_we) begin
      e.we = (wb_a != 0); e.a = wb_a; e.wd = wb_d;
    end else if (lv && (!dv || m_rr == 0)) begin
      e.lr = 1; e.we = (la != 0); e.a = la; e.wd = ld;
    end else if (dv) begin
      e.dr = 1; e.we = (da != 0); e.a = da; e.wd = dd;
    end
    return e;
  endfunction

  task automatic model_edge(input obs_t e);
    if (m_init && wb_we) m_err = 1;
    if (m_init) begin
      if (m_idx == 31) m_init = 0;
      else m_idx++;
    end
    if (e.lr) m_rr = 1;
    else if (e.dr) m_rr = 0;
    if (!lv || e.lr) m_wl = 0; else if (m_wl < LIM) m_wl++;
    if (!dv || e.dr) m_wd = 0; else if (m_wd < LIM) m_wd++;
  endtask

  vec_t tbl[9];

  initial begin
    obs_t e;
    bit hs_l, hs_d;
    int wb_pct;

    rst_n = 0;
    idle();

    // Reset and full sweep.
    do_reset();
    sweep(0);

    // Vector table in RUN; rr starts at LONG.
    tbl[0] = v(1, 5, 32'hDEADBEEF, 1, 6, 32'h66, 0, 0, 0,       mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0));
    tbl[1] = v(0, 0, 0,            1, 6, 32'h66, 0, 0, 0,       mk(1, 6, 32'h66, 1, 0, 0, 0, 0));
    tbl[2] = v(0, 0, 0,            0, 0, 0,      1, 0, 32'h1234, mk(0, 0, 32'h1234, 0, 1, 0, 0, 0));
    tbl[3] = v(0, 0, 0,            1, 7, 32'h77, 1, 8, 32'h88,  mk(1, 7, 32'h77, 1, 0, 0, 0, 0));
    tbl[4] = v(0, 0, 0,            1, 7, 32'h77, 1, 8, 32'h88,  mk(1, 8, 32'h88, 0, 1, 0, 0, 0));
    tbl[5] = v(0, 0, 0,            1, 7, 32'h77, 1, 8, 32'h88,  mk(1, 7, 32'h77, 1, 0, 0, 0, 0));
    tbl[6] = v(0, 0, 0,            1, 7, 32'h77, 1, 8, 32'h88,  mk(1, 8, 32'h88, 0, 1, 0, 0, 0));
    tbl[7] = v(0, 0, 0,            0, 0, 0,      0, 0, 0,       mk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl[8] = v(1, 0, 32'h5,        0, 0, 0,      0, 0, 0,       mk(0, 0, 32'h5, 0, 0, 0, 0, 0));
    for (int i = 0; i < 9; i++) begin
      wb_we = tbl[i].wb_we; wb_a = tbl[i].wb_a; wb_d = tbl[i].wb_d;
      lv = tbl[i].lv; la = tbl[i].la; ld = tbl[i].ld;
      dv = tbl[i].dv; da = tbl[i].da; dd = tbl[i].dd;
      @(negedge clk);
      chk($sformatf("vec%0d", i), dut_obs(), tbl[i].exp);
      @(posedge clk);
      #1;
    end

    // Starvation: WB hogs the port while LONG waits.
    wb_we = 1; wb_a = 9; wb_d = 32'h9999; lv = 1; la = 10; ld = 32'hAAAA;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("starve_k%0d", k), dut_obs(), mk(1, 9, 32'h9999, 0, 0, 0, k >= LIM, 0));
      @(posedge clk);
      #1;
    end
    wb_we = 0;
    @(negedge clk);
    chk("starve_grant", dut_obs(), mk(1, 10, 32'hAAAA, 1, 0, 0, 1, 0));
    @(posedge clk);
    #1 lv = 0;
    @(negedge clk);
    chk("starve_release", dut_obs(), mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Reset asserted in the middle of a granted handshake.
    @(posedge clk);
    #1 lv = 1; la = 12; ld = 32'hC;
    #2 chk("pre_abort", dut_obs(), mk(1, 12, 32'hC, 1, 0, 0, 0, 0));
    rst_n = 0;
    #1 chk("abort", dut_obs(), mk(0, 0, 0, 0, 0, 1, 0, 0));

    // WB pulse during the sweep: ignored, sticky error until the next reset.
    do_reset();
    sweep(10);
    repeat (3) begin
      @(negedge clk);
      chk("drop_sticky", dut_obs(), mk(0, 0, 0, 0, 0, 0, 0, 1));
      @(posedge clk);
      #1;
    end

    // Randomized traffic against the model, from a fresh reset.
    do_reset();
    m_init = 1; m_idx = 1; m_rr = 0; m_wl = 0; m_wd = 0; m_err = 0;
    hs_l = 0; hs_d = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      wb_pct = ((cyc / 250) % 2 == 1) ? 85 : 20;
      wb_we = ($urandom_range(0, 99) < wb_pct);
      wb_a  = 5'($urandom_range(0, 31));
      wb_d  = $urandom;
      if (lv && hs_l) lv = 0;
      if (!lv && $urandom_range(0, 99) < 45) begin
        lv = 1; la = 5'($urandom_range(0, 31)); ld = $urandom;
      end
      if (dv && hs_d) dv = 0;
      if (!dv && $urandom_range(0, 99) < 45) begin
        dv = 1; da = 5'($urandom_range(0, 31)); dd = $urandom;
      end
      @(negedge clk);
      e = model_eval();
      chk($sformatf("rand%0d", cyc), dut_obs(), e);
      @(posedge clk);
      model_edge(e);
      hs_l = e.lr; hs_d = e.dr;
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
